// File: rtl/pcm_sample_feeder.sv
// pcm_sample_feeder
//   Stereo frame FIFO sitting in front of the PCM5102 I2S DAC driver.
//   Producers push {left,right} frames over valid/ready; one frame is popped
//   onto the held left/right outputs on every rising edge of the DAC lrck.
//   An lrck rise with nothing stored is an underrun. In that case the outputs
//   either hold the last frame or mute, depending on UNDERRUN_MODE. The event
//   is recorded in a sticky flag and a saturating counter.
//
// Ports
//   clk, rst_n           system clock, synchronous active-low reset
//   in_valid/in_ready    producer handshake; in_left/in_right are the frame
//   lrck                 DAC word clock (same clock domain, already registered)
//   left/right           held samples to the DAC driver
//   sample_req           one-cycle pulse the cycle after each pop event
//   level                number of frames stored, 0..DEPTH
//   underrun             sticky underrun flag
//   underrun_cnt         saturating count of underrun pops
//   clr_status           clears underrun and underrun_cnt
module pcm_sample_feeder #(
    parameter int          DEPTH         = 8,
    parameter int          UNDERRUN_MODE = 0,
    parameter logic [15:0] MUTE_VALUE    = 16'h8000,
    parameter int          LW            = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_left,
    input  logic [15:0]   in_right,
    input  logic          lrck,
    output logic [15:0]   left,
    output logic [15:0]   right,
    output logic          sample_req,
    output logic [LW-1:0] level,
    output logic          underrun,
    output logic [15:0]   underrun_cnt,
    input  logic          clr_status
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    frame_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            lrck_q;
    logic            push;
    logic            pop_ev;
    logic            pop_ok;
    logic            pop_und;
    logic [LW-1:0]   level_next;
    frame_t          rd_frame;

    always_comb begin
        push       = in_valid & in_ready;
        pop_ev     = lrck & ~lrck_q;
        pop_ok     = pop_ev & (level != '0);
        pop_und    = pop_ev & (level == '0);
        rd_frame   = mem[rd_ptr];
        level_next = level;
        case ({push, pop_ok})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Storage has no reset; only the pointers and level decide what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem[wr_ptr] <= frame_t'({in_left, in_right});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            in_ready     <= 1'b0;
            // Starting high means an lrck already high at release is not a rise.
            lrck_q       <= 1'b1;
            left         <= MUTE_VALUE;
            right        <= MUTE_VALUE;
            sample_req   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            lrck_q     <= lrck;
            sample_req <= pop_ev;
            level      <= level_next;
            // Registered ready: looks at the level after this edge.
            in_ready   <= (level_next < FULL);

            if (push)
                wr_ptr <= wr_ptr + AW'(1);

            // When level > 0 a same-cycle push writes a different slot, so
            // reading rd_ptr here never sees the incoming frame.
            if (pop_ok) begin
                left   <= rd_frame.l;
                right  <= rd_frame.r;
                rd_ptr <= rd_ptr + AW'(1);
            end else if (pop_und && UNDERRUN_MODE == 1) begin
                left  <= MUTE_VALUE;
                right <= MUTE_VALUE;
            end

            // A clear takes priority over the flag, but an underrun pop in the
            // same cycle is still counted.
            if (clr_status) begin
                underrun     <= 1'b0;
                underrun_cnt <= pop_und ? 16'd1 : 16'd0;
            end else if (pop_und) begin
                underrun <= 1'b1;
                if (underrun_cnt != 16'hFFFF)
                    underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcm_sample_feeder.sv
// Testbench for pcm_sample_feeder. Two instances share the same stimulus:
// one holds the last frame on underrun and the other mutes. A queue-based
// model predicts the state after every clock. A scoreboard carries the
// expected output of each pop to a monitor, which compares it when
// sample_req appears.
module tb_pcm_sample_feeder;

    localparam int          DEPTH = 8;
    localparam int          LW    = $clog2(DEPTH) + 1;
    localparam logic [15:0] MUTE  = 16'h8000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [15:0]   in_left = '0;
    logic [15:0]   in_right = '0;
    logic          lrck = 1'b1;
    logic          clr_status = 1'b0;

    logic          h_ready, m_ready_o, h_sreq, m_sreq, h_und, m_und;
    logic [15:0]   h_left, h_right, m_left, m_right, h_cnt, m_cnt_o;
    logic [LW-1:0] h_level, m_level;

    pcm_sample_feeder #(.DEPTH(DEPTH), .UNDERRUN_MODE(0), .MUTE_VALUE(MUTE)) u_hold (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(h_ready),
        .in_left(in_left), .in_right(in_right), .lrck(lrck),
        .left(h_left), .right(h_right), .sample_req(h_sreq), .level(h_level),
        .underrun(h_und), .underrun_cnt(h_cnt), .clr_status(clr_status));

    pcm_sample_feeder #(.DEPTH(DEPTH), .UNDERRUN_MODE(1), .MUTE_VALUE(MUTE)) u_mute (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_ready_o),
        .in_left(in_left), .in_right(in_right), .lrck(lrck),
        .left(m_left), .right(m_right), .sample_req(m_sreq), .level(m_level),
        .underrun(m_und), .underrun_cnt(m_cnt_o), .clr_status(clr_status));

    always #5 clk = ~clk;

    // Reference model
    logic [31:0] mq[$];      // stored frames, oldest first
    logic [63:0] sbq[$];     // expected {hold L,R, mute L,R} per pop
    bit          md_lrck_q = 1'b1;
    bit          md_ready  = 1'b0;
    bit          md_und    = 1'b0;
    int          md_cnt    = 0;
    logic [15:0] ehl = MUTE, ehr = MUTE, eml = MUTE, emr = MUTE;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then check state.
    task automatic cyc(input bit v, input logic [15:0] l, input logic [15:0] r,
                       input bit lr, input bit clr, input bit rn);
        bit          pe, pu, ur;
        logic [31:0] f;
        rst_n = rn; in_valid = v; in_left = l; in_right = r;
        lrck = lr; clr_status = clr;
        if (!rn) begin
            mq.delete();
            md_lrck_q = 1'b1; md_ready = 1'b0; md_und = 1'b0; md_cnt = 0;
            ehl = MUTE; ehr = MUTE; eml = MUTE; emr = MUTE;
        end else begin
            pe = lr && !md_lrck_q;
            pu = v && md_ready;
            ur = 1'b0;
            if (pe) begin
                if (mq.size() > 0) begin
                    f = mq.pop_front();
                    ehl = f[31:16]; ehr = f[15:0]; eml = f[31:16]; emr = f[15:0];
                end else begin
                    ur = 1'b1;
                    eml = MUTE; emr = MUTE;
                end
                sbq.push_back({ehl, ehr, eml, emr});
            end
            if (pu) mq.push_back({l, r});
            if (clr) begin
                md_und = 1'b0;
                md_cnt = ur ? 1 : 0;
            end else if (ur) begin
                md_und = 1'b1;
                if (md_cnt < 65535) md_cnt++;
            end
            md_lrck_q = lr;
            md_ready  = (mq.size() < DEPTH);
        end
        @(posedge clk); #1;
        chk("level_hold", 32'(h_level), mq.size());
        chk("level_mute", 32'(m_level), mq.size());
        chk("in_ready", {30'd0, h_ready, m_ready_o}, {30'd0, md_ready, md_ready});
        chk("underrun", {30'd0, h_und, m_und}, {30'd0, md_und, md_und});
        chk("underrun_cnt_hold", 32'(h_cnt), md_cnt);
        chk("underrun_cnt_mute", 32'(m_cnt_o), md_cnt);
        chk("lr_hold", {h_left, h_right}, {ehl, ehr});
        chk("lr_mute", {m_left, m_right}, {eml, emr});
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        cyc(1'b1, l, r, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pop();
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every sample_req pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        logic [63:0] e;
        if (h_sreq || m_sreq) begin
            chk("sample_req_pair", {31'd0, h_sreq}, {31'd0, m_sreq});
            if (sbq.size() == 0) begin
                chk("unexpected_sample_req", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("pop_hold", {h_left, h_right}, e[63:32]);
                chk("pop_mute", {m_left, m_right}, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [15:0] l;
        bit          lr_r;

        // Reset with lrck high, then idle: no pop on release.
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);

        // Fill to DEPTH, attempt a ninth push, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            l = 16'(16'h1111 * i);
            push(l, 16'(16'hA000 + i));
        end
        chk("full_in_ready", {31'd0, h_ready}, 32'd0);
        push(16'h9999, 16'hA009);
        chk("full_level", 32'(h_level), 32'd8);
        repeat (8) pop();
        chk("drained_underrun", {31'd0, h_und}, 32'd0);

        // Push coinciding with a pop at level 3.
        push(16'h0101, 16'h0202);
        push(16'h0303, 16'h0404);
        push(16'h0505, 16'h0606);
        cyc(1'b1, 16'h0707, 16'h0808, 1'b1, 1'b0, 1'b1);
        chk("simul_level", 32'(h_level), 32'd3);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) pop();

        // Underrun: hold vs mute, then clear.
        push(16'h1234, 16'h5678);
        pop();
        repeat (2) pop();
        chk("und_cnt_two", 32'(h_cnt), 32'd2);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("clr_cnt", 32'(h_cnt), 32'd0);
        // Clear coinciding with an underrun pop; a push in that cycle plays next.
        cyc(1'b1, 16'hABCD, 16'hDCBA, 1'b1, 1'b1, 1'b1);
        chk("clr_und_cnt_one", 32'(h_cnt), 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        pop();

        // Pointer wrap: 20 frames streamed at level 1.
        push(16'd0, 16'd0);
        for (int k = 1; k < 20; k++) begin
            cyc(1'b1, 16'(k), 16'(k), 1'b1, 1'b0, 1'b1);
            cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        end
        pop();

        // Reset with five frames stored; the next pop is an underrun.
        for (int i = 0; i < 5; i++) push(16'(16'h5000 + i), 16'(16'h6000 + i));
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_level", 32'(h_level), 32'd0);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_underrun", {31'd0, h_und}, 32'd1);
        cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional clears and resets.
        lr_r = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) lr_r = ~lr_r;
            cyc(($urandom_range(0, 2) != 0), 16'($urandom), 16'($urandom), lr_r,
                ($urandom_range(0, 40) == 0), ($urandom_range(0, 150) != 0));
        end
        repeat (2) cyc(1'b0, 16'h0, 16'h0, lr_r, 1'b0, 1'b1);

        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcm_sample_feeder.md
Name: pcm_sample_feeder

Overview:
- Stereo sample buffer directly upstream of the PCM5102 I2S DAC driver.
- Synth or voice logic pushes left/right frames through a valid/ready handshake into a small FIFO.
- The block watches the DAC's lrck and pops one frame per audio period onto held `left`/`right` outputs that feed the DAC driver.
- Handles underrun by holding the last frame or muting, and reports a sticky flag and an underrun count.

Parameters:
- DEPTH, 8, FIFO depth in stereo frames; power of two, minimum 2.
- UNDERRUN_MODE, 0, 0 = hold last frame on underrun; 1 = output MUTE_VALUE on both channels.
- MUTE_VALUE, 16'h8000, output value at reset and on mute underrun (Uint16 midscale).
- LW, $clog2(DEPTH)+1, width of the level output (derived; do not override).

Ports:
- clk  input  1  system clock, 48 MHz.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has a frame on in_left/in_right.
- in_ready  output  1  block can accept a frame this cycle.
- in_left  input  16  left sample, Uint16.
- in_right  input  16  right sample, Uint16.
- lrck  input  1  lrck from the DAC driver, same clk domain, registered there.
- left  output  16  held left sample to the DAC driver.
- right  output  16  held right sample to the DAC driver.
- sample_req  output  1  one-cycle pulse per frame pop; producers may use it as a sample tick.
- level  output  LW  frames currently stored, 0..DEPTH.
- underrun  output  1  sticky: a pop occurred with the FIFO empty.
- underrun_cnt  output  16  count of underrun pops, saturating at 16'hFFFF.
- clr_status  input  1  clears underrun and underrun_cnt.

Behaviour:
- Reset (rst_n low at a clk edge):
  - left = right = MUTE_VALUE; level = 0; in_ready = 0; sample_req = 0; underrun = 0; underrun_cnt = 0.
  - Read/write pointers are 0. The internal lrck_q register is 1, so a high lrck at reset release produces no edge.
  - Reset mid-operation discards all stored frames.
- Storage: circular RAM of DEPTH x 32 bits {left, right}. Pointers are log2(DEPTH) bits and wrap naturally. level is a separate LW-bit counter.
- in_ready:
  - Registered. Equals (level_next < DEPTH) and is 1 from the first cycle after reset release.
  - When level = DEPTH, in_ready = 0.
- Push: occurs on a clk edge with in_valid & in_ready.
  - The frame is written at wr_ptr, then wr_ptr increments.
  - in_left/in_right are sampled only on a push.
- Pop event: lrck rising edge, defined as lrck = 1 while lrck_q = 0 at a clk edge. lrck_q <= lrck every cycle.
  - Popping on rising lrck gives half a frame of settling before the DAC driver latches on the falling lrck.
- Pop, level > 0:
  - left/right <= frame at rd_ptr on that same edge; rd_ptr increments.
  - The stored frame and a same-cycle push never alias, because level > 0 means the write targets a different slot.
- Pop, level = 0 (underrun):
  - UNDERRUN_MODE 0: left/right keep their current values. UNDERRUN_MODE 1: left/right <= MUTE_VALUE.
  - rd_ptr unchanged; underrun <= 1; underrun_cnt increments, saturating.
  - A push in the same cycle is stored but not forwarded; it plays at the next pop.
- sample_req = 1 for exactly the cycle after each pop event, whether or not an underrun occurred.
- level update:
  - push only: +1.
  - successful pop only: -1.
  - push and successful pop together: unchanged.
  - push and underrun pop: +1.
- clr_status:
  - Clears underrun and underrun_cnt on the next edge.
  - If it coincides with an underrun pop, the clear wins for underrun, and underrun_cnt becomes 1.
- left/right change only on a pop or a reset, never otherwise. This keeps them stable for the DAC driver's latch.
- Pops at most once per lrck period; no output depends combinationally on lrck.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 cycles with lrck = 1, then release. Required: left = right = 16'h8000, level = 0, in_ready = 1 from the 2nd cycle, no sample_req, underrun = 0.
- Fill and drain: push frames (16'h1111, 16'hA001) .. (16'h8888, 16'hA008) with DEPTH = 8 and no lrck edges. Required: level = 8, in_ready = 0, a 9th in_valid is not accepted. Then drive 8 lrck rising edges. Required: left/right step through 1111/A001 .. 8888/A008 in order, level reaches 0, underrun = 0.
- Simultaneous push and pop: with level = 3, assert in_valid in the same cycle as an lrck rise. Required: level stays 3, the oldest frame appears on left/right, and the new frame plays 3 pops later.
- Underrun: run with level = 0 and output 16'h1234/16'h5678, then drive 2 lrck rises. Required: UNDERRUN_MODE 0 holds 1234/5678 and UNDERRUN_MODE 1 outputs 8000/8000; underrun = 1, underrun_cnt = 2, sample_req pulses twice. Then pulse clr_status. Required: underrun = 0, underrun_cnt = 0.
- Pointer wrap: stream 20 frames with values 0..19 while popping, keeping level between 1 and 7. Required: output sequence 0..19 with no skips or repeats across the pointer wrap.
- Reset mid-stream: assert rst_n = 0 for 1 cycle with level = 5. Required: level = 0, outputs = 16'h8000, and the next pop is an underrun.
